// File: rtl/cam_match_iterator_pkg.sv
// cam_pkg: shared types and window helpers for cam_match_iterator.
// Optional feature macro: CAM_MATCH_COUNT_EN (see cam_match_iterator.sv).
package cam_pkg;

    localparam int CAM_INDEX_WIDTH = 5;
    localparam int CAM_DEPTH = 2 ** CAM_INDEX_WIDTH;

    typedef logic [CAM_INDEX_WIDTH-1:0] idx_t;
    typedef logic [CAM_DEPTH-1:0] vec_t;

    typedef enum logic {
        IDLE = 1'b0,
        ITER = 1'b1
    } iter_state_t;

    // Inclusive window membership; start > end means the window wraps.
    function automatic logic in_window(
        input int unsigned i,
        input int unsigned s,
        input int unsigned e
    );
        if (s <= e) return (i >= s) && (i <= e);
        return (i >= s) || (i <= e);
    endfunction

    function automatic vec_t window_mask(input idx_t s, input idx_t e);
        vec_t m;
        for (int i = 0; i < CAM_DEPTH; i++)
            m[i] = in_window(i, int'(s), int'(e));
        return m;
    endfunction

endpackage

// File: rtl/cam_match_iterator_if.sv
// Load / index handshake bundle for cam_match_iterator.
// match_count_o exists only when CAM_MATCH_COUNT_EN is defined.
interface cam_match_iterator_if #(
    parameter int INDEX_WIDTH = 5
);
    localparam int DEPTH = 2 ** INDEX_WIDTH;

    logic                   load_i;
    logic [DEPTH-1:0]       match_i;
    logic [INDEX_WIDTH-1:0] start_i;
    logic [INDEX_WIDTH-1:0] end_i;
    logic                   flush_i;
    logic                   load_ready_o;
    logic [INDEX_WIDTH-1:0] idx_o;
    logic                   idx_valid_o;
    logic                   idx_ready_i;
    logic                   last_o;
    logic                   none_o;
`ifdef CAM_MATCH_COUNT_EN
    logic [INDEX_WIDTH:0]   match_count_o;
`endif

    modport slave (
        input  load_i, match_i, start_i, end_i, flush_i, idx_ready_i,
`ifdef CAM_MATCH_COUNT_EN
        output match_count_o,
`endif
        output load_ready_o, idx_o, idx_valid_o, last_o, none_o
    );

    modport master (
        output load_i, match_i, start_i, end_i, flush_i, idx_ready_i,
`ifdef CAM_MATCH_COUNT_EN
        input  match_count_o,
`endif
        input  load_ready_o, idx_o, idx_valid_o, last_o, none_o
    );

endinterface

// File: rtl/cam_match_iterator_find_first.sv
// cam_find_first: circular find-first of a vector from a base index.
// Rotate so the walk starts at bit 0, priority search, then un-rotate.
module cam_find_first #(
    parameter int INDEX_WIDTH = 5,
    localparam int DEPTH = 2 ** INDEX_WIDTH
) (
    input  logic [DEPTH-1:0]       vec_i,
    input  logic [INDEX_WIDTH-1:0] base_i,
    input  logic                   asc_i,
    output logic [INDEX_WIDTH-1:0] idx_o,
    output logic                   found_o,
    output logic                   one_left_o
);

    logic [DEPTH-1:0]       rot;
    logic [INDEX_WIDTH-1:0] off;

    // rot[k] is the bit k steps away from base in the walk direction
    always_comb begin
        logic [INDEX_WIDTH-1:0] pos;
        rot = '0;
        pos = '0;
        for (int k = 0; k < DEPTH; k++) begin
            pos = asc_i ? base_i + INDEX_WIDTH'(k)
                        : base_i - INDEX_WIDTH'(k);
            rot[k] = vec_i[pos];
        end
    end

    // lowest set bit of the rotated vector is the nearest hit
    always_comb begin
        off = '0;
        found_o = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = INDEX_WIDTH'(k);
                found_o = 1'b1;
            end
        end
    end

    assign idx_o = asc_i ? base_i + off : base_i - off;
    assign one_left_o = (|vec_i) & ~(|(vec_i & (vec_i - DEPTH'(1))));

endmodule

// File: rtl/cam_match_iterator.sv
// cam_match_iterator: walks every windowed CAM hit, one per handshake.
// Define CAM_MATCH_COUNT_EN to add the remaining-match counter output.
module cam_match_iterator
    import cam_pkg::*;
#(
    parameter int INDEX_WIDTH = CAM_INDEX_WIDTH,
    parameter bit ASCENDING   = 1'b1
) (
    input logic clk,
    input logic rst,
    cam_match_iterator_if.slave bus
);

    localparam int DEPTH = 2 ** INDEX_WIDTH;
    localparam int CW    = INDEX_WIDTH + 1;

    iter_state_t            state_q, state_d;
    logic [DEPTH-1:0]       pending_q, pending_d;
    logic [DEPTH-1:0]       mask, masked;
    logic [INDEX_WIDTH-1:0] base_q, base_d;
    logic [INDEX_WIDTH-1:0] ff_idx;
    logic                   none_q, none_d;
    logic                   ff_found, ff_one_left;
    logic                   valid;
`ifdef CAM_MATCH_COUNT_EN
    logic [CW-1:0]          cnt_q, cnt_d, pop;
`endif

    // window mask built from the raw start/end inputs
    always_comb begin
        mask = '0;
        for (int i = 0; i < DEPTH; i++)
            mask[i] = in_window(i, int'(bus.start_i), int'(bus.end_i));
    end

    assign masked = bus.match_i & mask;

`ifdef CAM_MATCH_COUNT_EN
    // popcount of the windowed vector, captured at load
    always_comb begin
        pop = '0;
        for (int i = 0; i < DEPTH; i++)
            pop = pop + CW'(masked[i]);
    end
`endif

    cam_find_first #(
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_ff (
        .vec_i      (pending_q),
        .base_i     (base_q),
        .asc_i      (ASCENDING),
        .idx_o      (ff_idx),
        .found_o    (ff_found),
        .one_left_o (ff_one_left)
    );

    // next state: flush wins over load and acceptance
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        base_d    = base_q;
        none_d    = 1'b0;
`ifdef CAM_MATCH_COUNT_EN
        cnt_d     = cnt_q;
`endif
        if (bus.flush_i) begin
            state_d   = IDLE;
            pending_d = '0;
`ifdef CAM_MATCH_COUNT_EN
            cnt_d     = '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.load_i) begin
                        pending_d = masked;
                        base_d = ASCENDING ? bus.start_i : bus.end_i;
`ifdef CAM_MATCH_COUNT_EN
                        cnt_d = pop;
`endif
                        if (|masked) state_d = ITER;
                        else         none_d  = 1'b1;
                    end
                end
                ITER: begin
                    if (bus.idx_ready_i) begin
                        pending_d = pending_q & ~(DEPTH'(1) << ff_idx);
`ifdef CAM_MATCH_COUNT_EN
                        cnt_d = cnt_q - CW'(1);
`endif
                        if (ff_one_left) state_d = IDLE;
                    end
                end
            endcase
        end
    end

    // state registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            base_q    <= '0;
            none_q    <= 1'b0;
`ifdef CAM_MATCH_COUNT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            base_q    <= base_d;
            none_q    <= none_d;
`ifdef CAM_MATCH_COUNT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign valid            = (state_q == ITER) & ff_found;
    assign bus.load_ready_o = (state_q == IDLE);
    assign bus.idx_valid_o  = valid;
    assign bus.idx_o        = valid ? ff_idx : '0;
    assign bus.last_o       = valid & ff_one_left;
    assign bus.none_o       = none_q;
`ifdef CAM_MATCH_COUNT_EN
    assign bus.match_count_o = cnt_q;
`endif

endmodule
